// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..MAX_BITS data bits, optional parity,
// one or two stop bits, bit timing from an external oversample Tick.
module uart_tx_cfg #(
    parameter int OVS      = 16,
    parameter int MAX_BITS = 9
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Tick,
    input  logic                TxValid,
    output logic                TxReady,
    input  logic [MAX_BITS-1:0] TxData,
    input  logic [3:0]          NBits,
    input  logic [1:0]          ParityMode,
    input  logic                StopBits,
    output logic                Tx,
    output logic                TxBusy,
    output logic                TxDone
);

    localparam int CW = (OVS > 1) ? $clog2(OVS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          bit_q, bit_d;
    logic [MAX_BITS-1:0] sh_q, sh_d;
    logic [3:0]          nbits_q, nbits_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                stop2_q, stop2_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;

    logic [3:0]          nb_clamp;
    logic [MAX_BITS-1:0] data_in;
    logic                bit_end;

    // Clamp the requested width and blank payload bits above it
    always_comb begin
        nb_clamp = NBits;
        if (NBits < 4'd5) begin
            nb_clamp = 4'd5;
        end else if (NBits > 4'(MAX_BITS)) begin
            nb_clamp = 4'(MAX_BITS);
        end
        data_in = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            data_in[i] = TxData[i] & (4'(i) < nb_clamp);
        end
    end

    assign bit_end = Tick && (cnt_q == CW'(OVS - 1));

    // Frame sequencing: next state, tick counter and serial line value
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        nbits_d   = nbits_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != S_IDLE && Tick) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (TxValid && ready_q) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    bit_d     = '0;
                    sh_d      = data_in;
                    nbits_d   = nb_clamp;
                    par_en_d  = (ParityMode == 2'b01)
                             || (ParityMode == 2'b10);
                    par_bit_d = (^data_in) ^ (ParityMode == 2'b10);
                    stop2_d   = StopBits;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == nbits_q - 4'd1) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = sh_q[0];
                        sh_d  = sh_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && bit_q == 4'd0) begin
                        bit_d = 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            nbits_q   <= 4'd5;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            nbits_q   <= nbits_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign Tx      = tx_q;
    assign TxBusy  = busy_q;
    assign TxDone  = done_q;
    assign TxReady = ready_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: frames are predicted as a list of line
// levels, each held for OVS counted Ticks, and compared every cycle.
module tb_uart_tx_cfg;

    localparam int OVS  = 16;
    localparam int MAXB = 9;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            Tick;
    logic            TxValid;
    logic            TxReady;
    logic [MAXB-1:0] TxData;
    logic [3:0]      NBits;
    logic [1:0]      ParityMode;
    logic            StopBits;
    logic            Tx;
    logic            TxBusy;
    logic            TxDone;

    int checks = 0;
    int errors = 0;
    bit exp_bits[$];

    uart_tx_cfg #(.OVS(OVS), .MAX_BITS(MAXB)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Tick       (Tick),
        .TxValid    (TxValid),
        .TxReady    (TxReady),
        .TxData     (TxData),
        .NBits      (NBits),
        .ParityMode (ParityMode),
        .StopBits   (StopBits),
        .Tx         (Tx),
        .TxBusy     (TxBusy),
        .TxDone     (TxDone)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Line levels of one frame: start, data LSB first, parity, stops
    function automatic void build(input logic [MAXB-1:0] d,
                                  input int nb, input logic [1:0] pm,
                                  input logic s2);
        int n;
        bit p;
        n = (nb < 5) ? 5 : ((nb > MAXB) ? MAXB : nb);
        p = 1'b0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pm == 2'b01) exp_bits.push_back(p);
        if (pm == 2'b10) exp_bits.push_back(!p);
        exp_bits.push_back(1'b1);
        if (s2) exp_bits.push_back(1'b1);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            TxValid = 1'b0;
            Tick    = 1'($urandom_range(0, 1));
            step();
            chk("idle_tx", Tx, 1);
            chk("idle_done", TxDone, 0);
            chk("idle_busy", TxBusy, 0);
            chk("idle_ready", TxReady, 1);
        end
    endtask

    task automatic run_frame(input logic [MAXB-1:0] d,
                             input logic [3:0] nb,
                             input logic [1:0] pm, input logic s2,
                             input bit hold, input int abort_t);
        int t;
        int total;
        int quiet;
        build(d, int'(nb), pm, s2);
        total = exp_bits.size() * OVS;
        chk("pre_ready", TxReady, 1);
        TxData     = d;
        NBits      = nb;
        ParityMode = pm;
        StopBits   = s2;
        TxValid    = 1'b1;
        Tick       = 1'($urandom_range(0, 1));
        step();
        chk("acc_tx", Tx, 0);
        chk("acc_busy", TxBusy, 1);
        chk("acc_ready", TxReady, 0);
        t = 0;
        quiet = 0;
        while (t < total) begin
            Tick       = (quiet >= 4) || ($urandom_range(0, 2) == 0);
            TxValid    = hold ? 1'b1 : 1'($urandom_range(0, 1));
            TxData     = MAXB'($urandom);
            NBits      = 4'($urandom);
            ParityMode = 2'($urandom);
            StopBits   = 1'($urandom);
            step();
            if (Tick) begin
                t++;
                quiet = 0;
            end else begin
                quiet++;
            end
            if (abort_t > 0 && t == abort_t) begin
                Rst     = 1'b1;
                TxValid = 1'b1;
                Tick    = 1'b1;
                step();
                chk("rst_tx", Tx, 1);
                chk("rst_busy", TxBusy, 0);
                chk("rst_done", TxDone, 0);
                chk("rst_ready", TxReady, 0);
                Rst     = 1'b0;
                TxValid = 1'b0;
                Tick    = 1'b0;
                step();
                chk("rel_ready", TxReady, 1);
                chk("rel_done", TxDone, 0);
                chk("rel_tx", Tx, 1);
                return;
            end
            if (t < total) begin
                chk("tx", Tx, 32'(exp_bits[t / OVS]));
                chk("done0", TxDone, 0);
                chk("busy1", TxBusy, 1);
            end
        end
        chk("end_done", TxDone, 1);
        chk("end_busy", TxBusy, 0);
        chk("end_ready", TxReady, 1);
        chk("end_tx", Tx, 1);
        if (!hold) TxValid = 1'b0;
        Tick = 1'b0;
    endtask

    initial begin
        Rst        = 1'b1;
        Tick       = 1'b1;
        TxValid    = 1'b1;
        TxData     = '0;
        NBits      = 4'd8;
        ParityMode = 2'b00;
        StopBits   = 1'b0;
        step();
        step();
        chk("reset_tx", Tx, 1);
        chk("reset_busy", TxBusy, 0);
        chk("reset_done", TxDone, 0);
        chk("reset_ready", TxReady, 0);
        Rst     = 1'b0;
        TxValid = 1'b0;
        step();
        chk("first_ready", TxReady, 1);
        idle(2);

        run_frame(9'h0A5, 4'd8, 2'b00, 1'b0, 1'b0, 0);
        idle(1);
        run_frame(9'h035, 4'd7, 2'b01, 1'b0, 1'b0, 0);
        idle(1);
        run_frame(9'h000, 4'd8, 2'b10, 1'b1, 1'b0, 0);
        idle(1);
        run_frame(9'h1FF, 4'd15, 2'b00, 1'b0, 1'b0, 0);
        idle(1);
        run_frame(9'h1B6, 4'd2, 2'b11, 1'b0, 1'b0, 0);
        idle(1);

        run_frame(9'h055, 4'd8, 2'b00, 1'b0, 1'b1, 0);
        run_frame(9'h0AA, 4'd8, 2'b00, 1'b0, 1'b0, 0);
        idle(2);

        run_frame(9'h0C3, 4'd8, 2'b01, 1'b1, 1'b0, OVS * 3 + 5);
        idle(3);
        run_frame(9'h13C, 4'd9, 2'b01, 1'b1, 1'b0, 0);
        idle(1);

        for (int k = 0; k < 12; k++) begin
            bit h;
            h = (k < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_frame(MAXB'($urandom), 4'($urandom),
                      2'($urandom), 1'($urandom), h, 0);
            if (!h) idle(int'($urandom_range(1, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The module SHALL have parameter OVS, default 16, giving Tick pulses per bit period (legal range 4..64).
REQ-002 The module SHALL have parameter MAX_BITS, default 9, giving the maximum data bits per frame and the TxData width (legal range 5..9).
REQ-003 The module SHALL have port Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port Tick  input  1  oversample enable, one Clk cycle wide, synchronous to Clk; it SHALL NOT be used as a clock.
REQ-006 The module SHALL have port TxValid  input  1  request to send the frame on TxData.
REQ-007 The module SHALL have port TxReady  output  1  high when a request can be accepted.
REQ-008 The module SHALL have port TxData  input  MAX_BITS  payload, LSB transmitted first.
REQ-009 The module SHALL have port NBits  input  4  data bits per frame.
REQ-010 The module SHALL have port ParityMode  input  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
REQ-011 The module SHALL have port StopBits  input  1  stop bits: 0 = one stop bit, 1 = two stop bits.
REQ-012 The module SHALL have port Tx  output  1  serial line, registered, idle high.
REQ-013 The module SHALL have port TxBusy  output  1  high from acceptance until frame end.
REQ-014 The module SHALL have port TxDone  output  1  one-Clk-cycle pulse at frame end.

Function
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, with transitions IDLE->START->DATA->(PARITY if enabled)->STOP->IDLE.
REQ-016 TxReady SHALL be 1 only in IDLE; a transfer SHALL be accepted on the Clk edge where TxValid & TxReady.
REQ-017 On acceptance, the module SHALL latch TxData, NBits, ParityMode and StopBits; input changes during a frame SHALL have no effect.
REQ-018 NBits SHALL be clamped at latch time: values below 5 -> 5; values above MAX_BITS -> MAX_BITS.
REQ-019 On acceptance, the tick counter SHALL clear to 0; Tx SHALL go low and TxBusy high on the same edge (zero-cycle latency to start bit).
REQ-020 The tick counter SHALL advance only on Clk edges with Tick=1; a bit period SHALL end on the Tick where the counter equals OVS-1, at which point the counter wraps to 0.
REQ-021 Tx SHALL change only on the edge that ends a bit period, or on acceptance.
REQ-022 The DATA state SHALL shift out exactly the latched NBits bits, LSB first, one per bit period; bits above NBits SHALL be ignored.
REQ-023 The parity bit SHALL be computed over the transmitted data bits only: even -> XOR of the bits; odd -> inverted XOR.
REQ-024 STOP SHALL drive Tx=1 for 1 or 2 bit periods as latched.
REQ-025 At the end of the last stop period, on the same edge: TxDone=1 for one cycle, TxBusy=0, TxReady=1, state IDLE.
REQ-026 Back-to-back: with TxValid held high, the next frame SHALL be accepted on the cycle after TxDone, with a one-Clk idle-high gap and no extra bit period.
REQ-027 Frame length SHALL be (1+N+P+S)*OVS Ticks, where P ∈ {0,1} and S ∈ {1,2}.
REQ-028 Tick asserted in the acceptance cycle SHALL NOT be counted.

Reset
REQ-029 When Rst=1 at a Clk edge, the module SHALL set: Tx=1, TxBusy=0, TxDone=0, TxReady=0, state IDLE, counter 0, bit index 0.
REQ-030 TxReady SHALL go high on the first edge with Rst=0.
REQ-031 Reset mid-frame SHALL abort without a TxDone pulse; Tx SHALL return high on that edge.
REQ-032 Rst SHALL take priority over acceptance in the same cycle.

Verification
REQ-033 The bench SHALL cover: OVS=16, 8N1, TxData=0x0A5 -> Tx = 0,1,0,1,0,0,1,0,1,1, each 16 Ticks; TxDone pulses once after 160 Ticks.
REQ-034 The bench SHALL cover: 7E1, TxData=0x035 -> data 1,0,1,0,1,1,0; parity 0; stop 1; 10 bit periods total.
REQ-035 The bench SHALL cover: 8O2, TxData=0x000 -> 8 zeros, parity 1, two stop bits; TxDone after 192 Ticks.
REQ-036 The bench SHALL cover: NBits=15 with MAX_BITS=9, TxData=0x1FF -> exactly 9 ones, then stop; NBits=2 -> 5 data bits.
REQ-037 The bench SHALL cover: TxValid held high over two frames (0x55, 0xAA) -> second start bit begins one Clk after TxDone; TxData changed mid-frame has no effect.
REQ-038 The bench SHALL cover: Rst asserted during the DATA state -> Tx=1 and TxBusy=0 the next cycle, no TxDone; a new frame is accepted normally afterwards.
